// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the Common Data Bus between the functional units.
// Each FU result is parked in a 1-entry holding buffer. A round-robin
// arbiter picks one held result per cycle and drives it onto a registered
// CDB broadcast.
//
// Handshake: a result is transferred from FU i on a rising clock edge
// exactly when req_valid[i] and req_ready[i] are both high. req_ready does
// not look at req_valid, so there is no combinational loop. The CDB side
// has no back-pressure: cdb_valid is a one-cycle pulse per result.

`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif

`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

module cdb_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int TAG_WIDTH  = `PHYSICAL_REG_NUM_WIDTH,
   parameter int DATA_WIDTH = `REG_VAL_WIDTH,
   parameter int SRC_WIDTH  = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_wr_en,
   output logic                          cdb_valid,
   output logic [TAG_WIDTH-1:0]          cdb_tag,
   output logic [DATA_WIDTH-1:0]         cdb_data,
   output logic                          cdb_wr_en,
   output logic [SRC_WIDTH-1:0]          cdb_src
);

   // Scan index carries one extra bit so rr_ptr + offset never overflows
   // before the modulo wrap is applied.
   localparam int IW = SRC_WIDTH + 1;
   localparam logic [SRC_WIDTH-1:0] LAST_IDX = SRC_WIDTH'(NUM_REQ - 1);

   // Holding buffers
   logic [NUM_REQ-1:0]                 hold_valid_q, hold_valid_d;
   logic [NUM_REQ-1:0][TAG_WIDTH-1:0]  hold_tag_q,   hold_tag_d;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] hold_data_q,  hold_data_d;
   logic [NUM_REQ-1:0]                 hold_wr_en_q, hold_wr_en_d;

   // Round-robin pointer: the first slot to be considered this cycle
   logic [SRC_WIDTH-1:0]               rr_ptr_q, rr_ptr_d;

   // Registered broadcast
   logic                               cdb_valid_q, cdb_valid_d;
   logic [TAG_WIDTH-1:0]               cdb_tag_q,   cdb_tag_d;
   logic [DATA_WIDTH-1:0]              cdb_data_q,  cdb_data_d;
   logic                               cdb_wr_en_q, cdb_wr_en_d;
   logic [SRC_WIDTH-1:0]               cdb_src_q,   cdb_src_d;

   // Arbitration results
   logic [NUM_REQ-1:0]                 grant;
   logic                               any_grant;
   logic [SRC_WIDTH-1:0]               winner;
   logic [IW-1:0]                      scan_idx;
   logic [NUM_REQ-1:0]                 accept;

   // Round-robin pick: first held slot at or after rr_ptr, wrapping modulo NUM_REQ
   always_comb begin
      grant     = '0;
      any_grant = 1'b0;
      winner    = '0;
      scan_idx  = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         scan_idx = {1'b0, rr_ptr_q} + IW'(off);
         if (scan_idx >= IW'(NUM_REQ)) begin
            scan_idx = scan_idx - IW'(NUM_REQ);
         end
         if (!any_grant && hold_valid_q[scan_idx[SRC_WIDTH-1:0]]) begin
            any_grant                        = 1'b1;
            winner                           = scan_idx[SRC_WIDTH-1:0];
            grant[scan_idx[SRC_WIDTH-1:0]]   = 1'b1;
         end
      end
   end

   // A slot is ready when empty or being drained this cycle; nothing is
   // accepted during flush or while reset is held
   always_comb begin
      req_ready = '0;
      if (reset) begin
         req_ready = (~hold_valid_q | grant) & ~{NUM_REQ{flush}};
      end
      accept = req_valid & req_ready;
   end

   // Next state: refill/drain of hold slots and the broadcast register
   always_comb begin
      hold_valid_d = (hold_valid_q & ~grant) | accept;
      hold_tag_d   = hold_tag_q;
      hold_data_d  = hold_data_q;
      hold_wr_en_d = hold_wr_en_q;
      rr_ptr_d     = rr_ptr_q;
      cdb_valid_d  = 1'b0;
      cdb_wr_en_d  = 1'b0;
      cdb_tag_d    = cdb_tag_q;
      cdb_data_d   = cdb_data_q;
      cdb_src_d    = cdb_src_q;

      for (int i = 0; i < NUM_REQ; i++) begin
         if (accept[i]) begin
            hold_tag_d[i]   = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
            hold_data_d[i]  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            hold_wr_en_d[i] = req_wr_en[i];
         end
      end

      if (flush) begin
         // Flush discards every held result and restarts the scan at slot 0
         hold_valid_d = '0;
         rr_ptr_d     = '0;
      end else if (any_grant) begin
         cdb_valid_d = 1'b1;
         cdb_tag_d   = hold_tag_q[winner];
         cdb_data_d  = hold_data_q[winner];
         cdb_src_d   = winner;
         // Physical register 0 is hard-wired and never written
         cdb_wr_en_d = hold_wr_en_q[winner] & (hold_tag_q[winner] != '0);
         rr_ptr_d    = (winner == LAST_IDX) ? '0 : winner + SRC_WIDTH'(1);
      end
   end

   // State registers with asynchronous active-low clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_valid_q <= '0;
         hold_tag_q   <= '0;
         hold_data_q  <= '0;
         hold_wr_en_q <= '0;
         rr_ptr_q     <= '0;
         cdb_valid_q  <= 1'b0;
         cdb_tag_q    <= '0;
         cdb_data_q   <= '0;
         cdb_wr_en_q  <= 1'b0;
         cdb_src_q    <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_tag_q   <= hold_tag_d;
         hold_data_q  <= hold_data_d;
         hold_wr_en_q <= hold_wr_en_d;
         rr_ptr_q     <= rr_ptr_d;
         cdb_valid_q  <= cdb_valid_d;
         cdb_tag_q    <= cdb_tag_d;
         cdb_data_q   <= cdb_data_d;
         cdb_wr_en_q  <= cdb_wr_en_d;
         cdb_src_q    <= cdb_src_d;
      end
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_tag   = cdb_tag_q;
   assign cdb_data  = cdb_data_q;
   assign cdb_wr_en = cdb_wr_en_q;
   assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: 4 requesters, 6-bit tags, 32-bit data.
// Inputs change 1 time unit after each rising edge; outputs are checked there.

module tb_cdb_arbiter;

   localparam int NR = 4;
   localparam int TW = 6;
   localparam int DW = 32;
   localparam int SW = 2;

   logic              clk;
   logic              reset;
   logic              flush;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*TW-1:0]  req_tag;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_wr_en;
   logic              cdb_valid;
   logic [TW-1:0]     cdb_tag;
   logic [DW-1:0]     cdb_data;
   logic              cdb_wr_en;
   logic [SW-1:0]     cdb_src;

   int tests;
   int failed;

   cdb_arbiter #(
      .NUM_REQ(NR), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .SRC_WIDTH(SW)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_tag(req_tag), .req_data(req_data), .req_wr_en(req_wr_en),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .cdb_wr_en(cdb_wr_en), .cdb_src(cdb_src)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_req();
      req_valid = '0;
      req_tag   = '0;
      req_data  = '0;
      req_wr_en = '0;
   endtask

   task automatic set_req(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d,
                          input logic w);
      req_valid[i]         = 1'b1;
      req_tag[i*TW +: TW]  = t;
      req_data[i*DW +: DW] = d;
      req_wr_en[i]         = w;
   endtask

   task automatic chk_cdb(input string name, input logic [TW-1:0] t, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input logic w);
      chk({name, "_valid"}, 64'(cdb_valid), 64'd1);
      chk({name, "_tag"},   64'(cdb_tag),   64'(t));
      chk({name, "_data"},  64'(cdb_data),  64'(d));
      chk({name, "_src"},   64'(cdb_src),   64'(s));
      chk({name, "_wr_en"}, 64'(cdb_wr_en), 64'(w));
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      flush  = 1'b0;
      clr_req();

      // ---------------- reset with all requesters valid ----------------
      reset     = 1'b0;
      req_valid = 4'b1111;
      req_tag   = {6'd4, 6'd3, 6'd2, 6'd1};
      req_wr_en = 4'b1111;
      tick();
      chk("rst_ready_a", 64'(req_ready), 64'd0);
      chk("rst_valid_a", 64'(cdb_valid), 64'd0);
      tick();
      chk("rst_ready_b", 64'(req_ready), 64'd0);
      chk("rst_valid_b", 64'(cdb_valid), 64'd0);
      chk("rst_tag",     64'(cdb_tag),   64'd0);
      chk("rst_data",    64'(cdb_data),  64'd0);
      chk("rst_wr_en",   64'(cdb_wr_en), 64'd0);
      chk("rst_src",     64'(cdb_src),   64'd0);
      clr_req();
      reset = 1'b1;
      #1;
      chk("rel_ready", 64'(req_ready), 64'hF);
      tick();
      chk("rel_no_capture", 64'(cdb_valid), 64'd0);
      tick();
      chk("rel_no_capture2", 64'(cdb_valid), 64'd0);

      // ---------------- single result latency ----------------
      set_req(2, 6'd5, 32'hDEAD, 1'b1);
      tick();                                   // edge k: captured
      chk("lat_k_valid", 64'(cdb_valid), 64'd0);
      chk("lat_k_ready", 64'(req_ready), 64'hF);
      clr_req();
      tick();                                   // edge k+1
      chk_cdb("lat_k1", 6'd5, 32'hDEAD, 2'd2, 1'b1);
      tick();
      chk("lat_pulse", 64'(cdb_valid), 64'd0);
      chk("lat_tag_hold", 64'(cdb_tag), 64'd5);

      // rr_ptr is now 3: FU3 must beat FU0
      set_req(0, 6'd20, 32'h20, 1'b1);
      set_req(3, 6'd23, 32'h23, 1'b1);
      tick();
      chk("rr_ready", 64'(req_ready), 64'hE);
      clr_req();
      tick();
      chk_cdb("rr_first", 6'd23, 32'h23, 2'd3, 1'b1);
      chk("rr_ready2", 64'(req_ready), 64'hF);
      tick();
      chk_cdb("rr_second", 6'd20, 32'h20, 2'd0, 1'b1);
      tick();
      chk("rr_idle", 64'(cdb_valid), 64'd0);

      // ---------------- full contention from rr_ptr = 0 ----------------
      flush = 1'b1;                             // empty flush brings rr_ptr back to 0
      #1;
      chk("fl0_ready", 64'(req_ready), 64'd0);
      tick();
      flush = 1'b0;
      for (int i = 0; i < NR; i++) set_req(i, TW'(10 + i), DW'(100 + i), 1'b1);
      tick();
      chk("fc_ready0", 64'(req_ready), 64'h1);
      clr_req();
      tick();
      chk_cdb("fc_b0", 6'd10, 32'd100, 2'd0, 1'b1);
      chk("fc_ready1", 64'(req_ready), 64'h3);
      tick();
      chk_cdb("fc_b1", 6'd11, 32'd101, 2'd1, 1'b1);
      chk("fc_ready2", 64'(req_ready), 64'h7);
      tick();
      chk_cdb("fc_b2", 6'd12, 32'd102, 2'd2, 1'b1);
      chk("fc_ready3", 64'(req_ready), 64'hF);
      tick();
      chk_cdb("fc_b3", 6'd13, 32'd103, 2'd3, 1'b1);
      tick();
      chk("fc_done", 64'(cdb_valid), 64'd0);

      // ---------------- refill on grant (rr_ptr = 0) ----------------
      set_req(0, 6'd30, 32'h30, 1'b1);
      set_req(1, 6'd40, 32'h40, 1'b1);
      tick();                                   // both captured
      chk("rf_ready_a", 64'(req_ready), 64'hD);
      clr_req();
      set_req(0, 6'd31, 32'h31, 1'b1);
      tick();                                   // FU0 granted and refilled
      chk_cdb("rf_b0", 6'd30, 32'h30, 2'd0, 1'b1);
      chk("rf_ready_b", 64'(req_ready), 64'hE);
      clr_req();
      set_req(0, 6'd32, 32'h32, 1'b1);
      tick();                                   // FU1 granted, FU0 stalled one cycle
      chk_cdb("rf_b1", 6'd40, 32'h40, 2'd1, 1'b1);
      chk("rf_ready_c", 64'(req_ready), 64'hF);
      tick();                                   // FU0 granted, 32 accepted
      chk_cdb("rf_b2", 6'd31, 32'h31, 2'd0, 1'b1);
      clr_req();
      tick();
      chk_cdb("rf_b3", 6'd32, 32'h32, 2'd0, 1'b1);
      tick();
      chk("rf_done", 64'(cdb_valid), 64'd0);

      // ---------------- flush mid-drain (rr_ptr = 1) ----------------
      set_req(1, 6'd51, 32'h51, 1'b1);
      set_req(2, 6'd52, 32'h52, 1'b1);
      set_req(3, 6'd53, 32'h53, 1'b1);
      tick();
      clr_req();
      tick();
      chk_cdb("fl_b0", 6'd51, 32'h51, 2'd1, 1'b1);
      flush = 1'b1;
      set_req(0, 6'd60, 32'h60, 1'b1);
      #1;
      chk("fl_ready", 64'(req_ready), 64'd0);
      tick();
      chk("fl_valid", 64'(cdb_valid), 64'd0);
      flush = 1'b0;
      clr_req();
      #1;
      chk("fl_ready_after", 64'(req_ready), 64'hF);
      tick();
      chk("fl_dropped", 64'(cdb_valid), 64'd0);
      tick();
      chk("fl_empty", 64'(cdb_valid), 64'd0);
      set_req(0, 6'd61, 32'h61, 1'b1);
      set_req(3, 6'd63, 32'h63, 1'b1);
      tick();
      clr_req();
      tick();
      chk_cdb("fl_rr0", 6'd61, 32'h61, 2'd0, 1'b1);
      tick();
      chk_cdb("fl_rr3", 6'd63, 32'h63, 2'd3, 1'b1);
      tick();
      chk("fl_done", 64'(cdb_valid), 64'd0);

      // ---------------- tag 0 and no-write results ----------------
      set_req(1, 6'd0, 32'h77, 1'b1);
      tick();
      clr_req();
      tick();
      chk_cdb("t0", 6'd0, 32'h77, 2'd1, 1'b0);
      set_req(2, 6'd7, 32'h88, 1'b0);
      tick();
      clr_req();
      tick();
      chk_cdb("st", 6'd7, 32'h88, 2'd2, 1'b0);
      tick();

      // ---------------- asynchronous reset mid-operation ----------------
      set_req(0, 6'd21, 32'hA1, 1'b1);
      set_req(1, 6'd22, 32'hA2, 1'b1);
      set_req(2, 6'd24, 32'hA4, 1'b1);
      tick();
      clr_req();
      tick();
      chk("ar_before", 64'(cdb_valid), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("ar_valid", 64'(cdb_valid), 64'd0);
      chk("ar_tag",   64'(cdb_tag),   64'd0);
      chk("ar_ready", 64'(req_ready), 64'd0);
      tick();
      reset = 1'b1;
      tick();
      chk("ar_rel_a", 64'(cdb_valid), 64'd0);
      tick();
      chk("ar_rel_b", 64'(cdb_valid), 64'd0);
      chk("ar_rel_ready", 64'(req_ready), 64'hF);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single Common Data Bus (CDB) between all functional units (`NUM_OF_ALUS ALUs plus `NUM_OF_MEM memory units) completing results in the same cycle.
- Each FU result is captured into a 1-entry holding buffer per requester, so the FU can accept new work immediately.
- A round-robin arbiter picks one held result per cycle and drives it onto a registered CDB broadcast.
- The CDB broadcast is consumed by the reservation-station unit and the physical register file.

Parameters:
NUM_REQ, 4, number of requesting FUs (ALUs first, then MEM units)
TAG_WIDTH, `PHYSICAL_REG_NUM_WIDTH, physical destination register tag width
DATA_WIDTH, `REG_VAL_WIDTH, result value width
SRC_WIDTH, $clog2(NUM_REQ), width of the winner index

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous flush from branch misprediction unit
req_valid  in  NUM_REQ  FU i presents a completed result
req_ready  out  NUM_REQ  holding buffer i can accept this cycle
req_tag  in  NUM_REQ*TAG_WIDTH  destination phy reg of FU i, slice i
req_data  in  NUM_REQ*DATA_WIDTH  result value of FU i, slice i
req_wr_en  in  NUM_REQ  result writes a register (0 for branch/store)
cdb_valid  out  1  CDB broadcast valid
cdb_tag  out  TAG_WIDTH  broadcast phy reg tag
cdb_data  out  DATA_WIDTH  broadcast value
cdb_wr_en  out  1  broadcast writes register file
cdb_src  out  SRC_WIDTH  index of the FU that won

Behaviour:
- Reset (reset==0, asynchronous):
  - hold_valid all 0; rr_ptr=0.
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_wr_en=0, cdb_src=0.
  - req_ready forced all 0 while reset is asserted.
- State: per requester hold_valid/hold_tag/hold_data/hold_wr_en; rr_ptr (SRC_WIDTH); registered CDB outputs.
- Ready (combinational): req_ready[i] = ~flush & (~hold_valid[i] | grant[i]).
  - No dependency on req_valid, so there is no combinational loop.
  - A buffer freed by a grant can be refilled in the same cycle.
- Accept: req_valid[i] & req_ready[i] at posedge captures the slice into hold i and sets hold_valid[i].
- Arbitration (combinational over hold_valid):
  - Scan i = rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ; the first set hold_valid wins.
  - grant is one-hot or zero.
- Grant update at posedge:
  - Winner's hold entry is copied to the cdb_* registers; cdb_valid=1; cdb_src=winner.
  - hold_valid[winner] clears unless it is refilled in the same cycle.
  - rr_ptr = (winner+1) mod NUM_REQ; wrap is required for non-power-of-2 NUM_REQ.
- No winner: cdb_valid=0 next cycle; cdb_tag/data hold their last value; rr_ptr unchanged.
- cdb_wr_en = hold_wr_en & (hold_tag != 0); physical reg 0 is never written.
- Latency:
  - Result accepted at edge k appears on the CDB at edge k+1 at the earliest (zero contention).
  - Worst case is edge k+NUM_REQ.
- Fairness: a held entry is granted within NUM_REQ cycles of becoming held. No starvation.
- Throughput: 1 broadcast per cycle while any hold_valid is set.
- Each cdb_valid is a single-cycle pulse per result. Each accepted result is broadcast exactly once, in per-FU order.
- Flush (sync, priority over accept and grant):
  - At the posedge with flush=1: hold_valid all 0, cdb_valid=0, rr_ptr=0.
  - Inputs in the flush cycle are dropped (req_ready=0).
  - Normal operation resumes the next cycle.
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock edge. Held results are lost. No cdb_valid pulse on reset release.
- Simultaneous events:
  - All NUM_REQ requesters valid in one cycle are all accepted; they drain over NUM_REQ cycles in round-robin order.
  - A refill while the same slot is being granted is legal and must not lose or duplicate results.

Test Plan:
1. Reset check: hold reset=0 for 2 cycles with req_valid=4'b1111 -> req_ready=0, cdb_valid=0, no captures. Release -> req_ready=4'b1111.
2. Single result latency: FU2 valid with tag=5, data=32'hDEAD, wr_en=1 at edge k -> cdb_valid=1, cdb_tag=5, cdb_data=32'hDEAD, cdb_src=2, cdb_wr_en=1 at edge k+1 only. rr_ptr becomes 3.
3. Full contention: all 4 valid at once with tags 10..13, rr_ptr=0 -> broadcasts tag 10,11,12,13 on 4 consecutive cycles. req_ready=0 for still-held slots; no loss or duplicate.
4. Refill on grant: FU0 valid on 3 consecutive cycles, FU1 valid once -> FU0 is never stalled more than 1 cycle. FU1 is broadcast within 2 cycles. Exact per-FU order is preserved.
5. Flush mid-drain: 3 entries held, flush=1 for one cycle -> cdb_valid=0 next cycle, hold empty, rr_ptr=0. A FU valid in the flush cycle is dropped.
6. Tag-0 and no-write: tag=0 with wr_en=1 -> cdb_valid=1, cdb_wr_en=0. A store with wr_en=0 -> cdb_valid=1, cdb_wr_en=0.
